otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
- Shares one single-port OTTER memory between the instruction-fetch requester (IF) and the load/store requester (DM).
- Sits between the control unit / datapath and the memory wrapper, and replaces the direct memRDEN1 / memRDEN2 / memWE2 wiring.
- Serialises accesses through a 3-state FSM and latches request fields.
- Enforces a bounded memory latency with a timeout that reports an error.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 15, maximum MEM-state cycles before abort (1..255).

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- RST  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  AW  fetch address (word read, size fixed 2'b10)
- if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DW  fetched word
- dm_req  in  1  data request; held high until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_size  in  2  00 byte, 01 half, 10 word
- dm_ack  out  1  one-cycle pulse: data access complete
- dm_rdata  out  DW  load data (0 for stores)
- mem_req  out  1  memory access strobe, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_size  out  2  access size
- mem_rdata  in  DW  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion; may arrive in the same cycle as mem_req
- err  out  1  one-cycle pulse coincident with the aborting ack on timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- States: IDLE, MEM, RESP.
- Reset: state=IDLE; all outputs 0; latched fields 0; timeout counter 0; owner=IF.
- Request protocol: requesters hold req and all fields stable until their ack. An ack is a single-cycle pulse. req may drop the cycle after ack.
- IDLE, sampling requests:
  - dm_req=1: owner=DM; latch dm_we/addr/wdata/size; go to MEM.
  - else if_req=1: owner=IF; latch if_addr with we=0, size=10; go to MEM.
  - Both asserted: DM wins (fixed priority).
- MEM:
  - mem_req=1 and mem_* driven from the latched registers only, never combinationally from requester inputs.
  - Counter increments each cycle.
  - mem_ack=1: capture mem_rdata (0 if we=1); go to RESP.
  - counter reaches TIMEOUT-1 without mem_ack: capture 0, set error flag, go to RESP; mem_req drops the next cycle.
- RESP:
  - Owner's ack=1 and its rdata=captured value; err=flag.
  - Non-owner's ack stays 0.
  - Go to IDLE; clear counter and flag.
- rdata outputs hold their last captured value between acks.
- Latency: req sampled in IDLE at cycle N; mem_req at N+1; with mem_ack at N+1, ack at N+2; next grant no earlier than N+3.
- A mem_ack while not in MEM is ignored.
- Requests arriving during MEM/RESP wait; the held req is sampled on return to IDLE.
- Reset mid-operation: next edge forces IDLE, mem_req=0, no ack issued. The requester must re-issue.
- Word accesses need not be aligned; alignment checks belong to the memory wrapper.

Optional Feature:
- Macro OTTER_ARB_RR_EN.
- Defined:
  - A last-grant bit is cleared by reset to IF.
  - When both requests are high in IDLE, grant the port that was not last granted.
  - A single requester is always granted.
- Undefined: fixed DM-over-IF priority as above, with no extra state.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0100, memory acks the same cycle with 0x0000_0513 -> mem_req at cycle 1, if_ack=1 with if_rdata=0x0000_0513 at cycle 2, dm_ack stays 0.
- Store: dm_req=1, dm_we=1, dm_addr=0x0000_6000, dm_wdata=0xDEAD_BEEF, dm_size=10, mem_ack after 3 cycles -> mem_we=1 with fields stable for all 3 cycles, dm_ack pulse, dm_rdata=0.
- Contention: if_req and dm_req both held from cycle 0 -> DM serviced first, IF granted immediately after DM's RESP. With OTTER_ARB_RR_EN, a second contention round grants IF before DM.
- Timeout: TIMEOUT=15, dm load with no mem_ack -> mem_req high exactly 15 cycles, then dm_ack=1, err=1, dm_rdata=0.
- Reset mid-access: RST asserted during MEM -> next cycle busy=0, mem_req=0, no ack. A request after RST deasserts completes normally.
- Stale ack: mem_ack pulsed while in IDLE -> no ack, no state change.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing one single-port OTTER memory between instruction fetch (IF) and load/store (DM).
// Optional macro OTTER_ARB_RR_EN switches contention from fixed DM priority to round-robin.
module otter_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  input  logic [1:0]    dm_size,
  output logic          dm_ack,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_size,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  localparam logic       OWN_IF  = 1'b0;
  localparam logic       OWN_DM  = 1'b1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    size_q, size_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_flag_q, err_flag_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          grant_dm;
  logic [DW-1:0] capture;
  logic          finish;

`ifdef OTTER_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // Under contention the port that did not win last time is granted.
  assign grant_dm = dm_req && (!if_req || (last_grant_q == OWN_IF));

  always_ff @(posedge clk) begin
    if (RST) last_grant_q <= OWN_IF;
    else     last_grant_q <= last_grant_d;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE) begin
      if (grant_dm)    last_grant_d = OWN_DM;
      else if (if_req) last_grant_d = OWN_IF;
    end
  end
`else
  assign grant_dm = dm_req;
`endif

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      err_flag_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      err_flag_q <= err_flag_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    err_flag_d = err_flag_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    capture    = '0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          owner_d = OWN_DM;
          we_d    = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          size_d  = dm_size;
          state_d = MEM;
        end else if (if_req) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = if_addr;
          wdata_d = '0;
          size_d  = 2'b10;
          state_d = MEM;
        end
      end
      MEM: begin
        cnt_d = 8'(cnt_q + 8'd1);
        if (mem_ack) begin
          capture = we_q ? '0 : mem_rdata;
          finish  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          err_flag_d = 1'b1;
          finish     = 1'b1;
        end
        // Captured data goes straight into the owner's output register so it holds between acks.
        if (finish) begin
          state_d = RESP;
          if (owner_q == OWN_DM) dm_rdata_d = capture;
          else                   if_rdata_d = capture;
        end
      end
      RESP: begin
        state_d    = IDLE;
        cnt_d      = '0;
        err_flag_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == MEM);
    mem_we    = (state_q == MEM) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_size  = size_q;
    if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
    dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
    err       = (state_q == RESP) && err_flag_q;
    busy      = (state_q != IDLE);
    if_rdata  = if_rdata_q;
    dm_rdata  = dm_rdata_q;
  end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed self-checking bench for otter_mem_arbiter (default build: fixed DM priority).
module tb_otter_mem_arbiter;

  logic        clk = 1'b0;
  logic        RST;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [1:0]  dm_size;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;
  logic        busy;

  int errors = 0;
  int checks = 0;

  otter_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single fetch, memory answers in the first MEM cycle.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] data);
    if_req  = 1'b1;
    if_addr = addr;
    tick();
    check("fetch_mem_req", 32'(mem_req), 32'd1);
    check("fetch_mem_addr", mem_addr, addr);
    check("fetch_mem_we", 32'(mem_we), 32'd0);
    check("fetch_mem_size", 32'(mem_size), 32'd2);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("fetch_if_ack", 32'(if_ack), 32'd1);
    check("fetch_if_rdata", if_rdata, data);
    check("fetch_dm_ack", 32'(dm_ack), 32'd0);
    check("fetch_err", 32'(err), 32'd0);
    check("fetch_mem_req_drop", 32'(mem_req), 32'd0);
    if_req = 1'b0;
    tick();
    check("fetch_if_ack_pulse", 32'(if_ack), 32'd0);
    check("fetch_idle", 32'(busy), 32'd0);
    check("fetch_rdata_hold", if_rdata, data);
  endtask

  task automatic run_load(input logic [31:0] addr, input logic [31:0] data);
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = addr;
    dm_size = 2'b10;
    tick();
    check("load_mem_addr", mem_addr, addr);
    check("load_mem_we", 32'(mem_we), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("load_dm_ack", 32'(dm_ack), 32'd1);
    check("load_dm_rdata", dm_rdata, data);
    check("load_if_ack", 32'(if_ack), 32'd0);
    dm_req = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_size = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_if_ack", 32'(if_ack), 32'd0);
    check("rst_dm_ack", 32'(dm_ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    RST = 1'b0;
    tick();

    run_fetch(32'h0000_0100, 32'h0000_0513);
    run_load(32'h0000_6004, 32'hCAFE_0001);
    check("load_if_rdata_kept", if_rdata, 32'h0000_0513);

    // Store with memory ack on the third MEM cycle.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_6000;
    dm_wdata = 32'hDEAD_BEEF; dm_size = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("st_mem_req", 32'(mem_req), 32'd1);
      check("st_mem_we", 32'(mem_we), 32'd1);
      check("st_mem_addr", mem_addr, 32'h0000_6000);
      check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("st_mem_size", 32'(mem_size), 32'd2);
      check("st_dm_ack_early", 32'(dm_ack), 32'd0);
      if (c == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end
    end
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("st_dm_ack", 32'(dm_ack), 32'd1);
    check("st_dm_rdata", dm_rdata, 32'd0);
    check("st_err", 32'(err), 32'd0);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();

    run_load(32'h0000_6008, 32'h1111_2222);

    // Timeout: no mem_ack ever arrives.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_7000; dm_size = 2'b10;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check("to_mem_req", 32'(mem_req), 32'd1);
      check("to_dm_ack_early", 32'(dm_ack), 32'd0);
    end
    tick();
    check("to_mem_req_drop", 32'(mem_req), 32'd0);
    check("to_dm_ack", 32'(dm_ack), 32'd1);
    check("to_err", 32'(err), 32'd1);
    check("to_dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    tick();
    check("to_err_pulse", 32'(err), 32'd0);
    check("to_idle", 32'(busy), 32'd0);

    // Contention: DM first, IF right after DM's response.
    if_req = 1'b1; if_addr = 32'h0000_0104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_6010; dm_size = 2'b01;
    tick();
    check("ct_dm_addr", mem_addr, 32'h0000_6010);
    check("ct_dm_size", 32'(mem_size), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_ABCD;
    tick();
    mem_ack = 1'b0;
    check("ct_dm_ack", 32'(dm_ack), 32'd1);
    check("ct_if_wait", 32'(if_ack), 32'd0);
    check("ct_dm_rdata", dm_rdata, 32'h0000_ABCD);
    dm_req = 1'b0;
    tick();
    check("ct_idle_gap", 32'(busy), 32'd0);
    tick();
    check("ct_if_mem_req", 32'(mem_req), 32'd1);
    check("ct_if_addr", mem_addr, 32'h0000_0104);
    check("ct_if_size", 32'(mem_size), 32'd2);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0093;
    tick();
    mem_ack = 1'b0;
    check("ct_if_ack", 32'(if_ack), 32'd1);
    check("ct_if_rdata", if_rdata, 32'h0000_0093);
    check("ct_dm_quiet", 32'(dm_ack), 32'd0);
    if_req = 1'b0;
    tick();

    // Reset in the middle of an access.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_8000; dm_size = 2'b10;
    tick();
    check("rm_mem_req", 32'(mem_req), 32'd1);
    RST = 1'b1; dm_req = 1'b0;
    tick();
    check("rm_busy", 32'(busy), 32'd0);
    check("rm_mem_req", 32'(mem_req), 32'd0);
    check("rm_dm_ack", 32'(dm_ack), 32'd0);
    RST = 1'b0;
    tick();
    check("rm_no_ack", 32'(dm_ack), 32'd0);
    run_fetch(32'h0000_0200, 32'h1234_5678);

    // Stale memory ack in IDLE.
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick();
    mem_ack = 1'b0; mem_rdata = '0;
    check("stale_busy", 32'(busy), 32'd0);
    check("stale_if_ack", 32'(if_ack), 32'd0);
    check("stale_dm_ack", 32'(dm_ack), 32'd0);
    tick();
    check("stale_busy2", 32'(busy), 32'd0);
    check("stale_if_ack2", 32'(if_ack), 32'd0);
    check("stale_if_rdata", if_rdata, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
